// File: rtl/xadc_drp_ctrl.sv
// -----------------------------------------------------------------------------
// xadc_drp_ctrl
//
// Bridges a simple user request interface to the XADC Dynamic Reconfiguration
// Port. While rd is held high, every end-of-conversion pulse becomes one DRP
// read of the converted channel. The result is returned on data_out together
// with a one-cycle valid strobe. A single-cycle wr request performs one DRP
// register write, and its completion is also signalled by valid. If drdy does
// not arrive in time, the access is abandoned and the controller returns to
// IDLE without raising valid.
//
// Optional build macro:
//   XADC_JTAG_LOCK_EN - while jtaglocked is high, new accesses are held off.
//                       Requests stay pending until the lock drops. Without
//                       the macro, jtaglocked is ignored.
//
// Ports:
//   clk        in   DRP/system clock; all logic runs on the rising edge
//   rst        in   asynchronous active-low reset
//   rd         in   level; while high, read each completed conversion
//   wr         in   single-cycle request to write data_in to addr
//   addr       in   DRP write address                    [ADDR_W]
//   data_in    in   DRP write data                       [DATA_W]
//   data_out   out  last DRP read result                 [DATA_W]
//   valid      out  one-cycle strobe when a read or a write completes
//   jtaglocked in   XADC JTAG lock status
//   busy       in   XADC busy; status only
//   drdy       in   DRP ready/acknowledge
//   eoc        in   end-of-conversion pulse
//   eos        in   end-of-sequence pulse; has no effect
//   channel    in   channel of the current conversion    [CH_W]
//   dout       in   DRP read data                        [DATA_W]
//   dwe        out  DRP write enable
//   den        out  DRP enable, one-cycle pulse per access
//   daddr      out  DRP address; holds between accesses  [ADDR_W]
//   din        out  DRP write data; holds between writes [DATA_W]
// -----------------------------------------------------------------------------
module xadc_drp_ctrl #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 7,
  parameter int CH_W    = 5,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              valid,
  input  logic              jtaglocked,
  input  logic              busy,
  input  logic              drdy,
  input  logic              eoc,
  input  logic              eos,
  input  logic [CH_W-1:0]   channel,
  input  logic [DATA_W-1:0] dout,
  output logic              dwe,
  output logic              den,
  output logic [ADDR_W-1:0] daddr,
  output logic [DATA_W-1:0] din
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE, WAIT_EOC, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, DONE
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   counter;
  logic               lock;
  logic               ld_wr, ld_rd;
  logic               timed_out;

  // busy and eos are status-only inputs; they are gathered here so that they
  // are visibly consumed.
  logic unused_inputs;
  assign unused_inputs = &{1'b0, busy, eos, jtaglocked};

`ifdef XADC_JTAG_LOCK_EN
  assign lock = jtaglocked;
`else
  assign lock = 1'b0;
`endif

  // The counter holds the number of completed wait cycles. If drdy arrives on
  // the same cycle the counter reaches TIMEOUT, the access still completes.
  assign timed_out = (counter == CNT_W'(TIMEOUT));

  // Next-state logic. ld_wr and ld_rd mark the cycle on which a request is
  // accepted, so the address and data registers latch on that cycle only.
  always_comb begin
    // NOTE: every output of this block gets a default first; otherwise any
    // path that skips an assignment infers a latch.
    state_nxt = state;
    ld_wr     = 1'b0;
    ld_rd     = 1'b0;
    unique case (state)
      IDLE: begin
        // wr wins over rd. A locked wr stays in IDLE so it is not lost on the
        // way through WAIT_EOC, where wr is ignored.
        if (wr) begin
          if (!lock) begin
            ld_wr     = 1'b1;
            state_nxt = WR_REQ;
          end
        end else if (rd && eoc && !lock) begin
          ld_rd     = 1'b1;
          state_nxt = RD_REQ;
        end else if (rd) begin
          state_nxt = WAIT_EOC;
        end
      end
      WAIT_EOC: begin
        if (eoc && !lock) begin
          ld_rd     = 1'b1;
          state_nxt = RD_REQ;
        end else if (!rd) begin
          state_nxt = IDLE;
        end
      end
      RD_REQ:  state_nxt = RD_WAIT;
      WR_REQ:  state_nxt = WR_WAIT;
      RD_WAIT, WR_WAIT: begin
        if (drdy)           state_nxt = DONE;
        else if (timed_out) state_nxt = IDLE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The DRP strobes and valid decode directly from the state register, so
  // each is exactly one cycle long and drops as soon as reset is applied.
  assign den   = (state == RD_REQ) || (state == WR_REQ);
  assign dwe   = (state == WR_REQ);
  assign valid = (state == DONE);

  // NOTE: sequential state uses non-blocking assignments so that every
  // register samples values from before the clock edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      counter  <= '0;
      daddr    <= '0;
      din      <= '0;
      data_out <= '0;
    end else begin
      state <= state_nxt;

      if (state == RD_REQ || state == WR_REQ) begin
        counter <= '0;
      end else if (state == RD_WAIT || state == WR_WAIT) begin
        counter <= counter + 1'b1;
      end

      if (ld_wr) begin
        daddr <= addr;
        din   <= data_in;
      end else if (ld_rd) begin
        daddr <= ADDR_W'(channel);
      end

      if (state == RD_WAIT && drdy) begin
        data_out <= dout;
      end
    end
  end

endmodule

// File: tb/tb_xadc_drp_ctrl.sv
// -----------------------------------------------------------------------------
// tb_xadc_drp_ctrl
//
// Directed bench for xadc_drp_ctrl. It covers reset, a single read, streaming
// reads, write priority, the drdy timeout boundary, reset during a pending
// access, and jtaglocked handling for both builds of XADC_JTAG_LOCK_EN.
// Inputs are driven 1 ns after the rising edge. Outputs are checked at the
// same point, so each check sees the state after that edge.
// -----------------------------------------------------------------------------
module tb_xadc_drp_ctrl;

  localparam int DATA_W  = 16;
  localparam int ADDR_W  = 7;
  localparam int CH_W    = 5;
  localparam int TIMEOUT = 255;

  logic              clk = 1'b0;
  logic              rst;
  logic              rd, wr;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              valid;
  logic              jtaglocked, busy, drdy, eoc, eos;
  logic [CH_W-1:0]   channel;
  logic [DATA_W-1:0] dout;
  logic              dwe, den;
  logic [ADDR_W-1:0] daddr;
  logic [DATA_W-1:0] din;

  int checks    = 0;
  int errors    = 0;
  int den_count = 0;
  int den_snap;

  xadc_drp_ctrl #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .CH_W   (CH_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rd         (rd),
    .wr         (wr),
    .addr       (addr),
    .data_in    (data_in),
    .data_out   (data_out),
    .valid      (valid),
    .jtaglocked (jtaglocked),
    .busy       (busy),
    .drdy       (drdy),
    .eoc        (eoc),
    .eos        (eos),
    .channel    (channel),
    .dout       (dout),
    .dwe        (dwe),
    .den        (den),
    .daddr      (daddr),
    .din        (din)
  );

  always #5 clk = ~clk;

  // Counts every cycle in which den is high, sampled mid-cycle.
  always @(negedge clk) if (den === 1'b1) den_count++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Starts from IDLE or WAIT_EOC with rd high. Pulses eoc, answers drdy two
  // cycles after den, and checks the returned data and the single valid.
  task automatic read_txn(input string tag, input logic [CH_W-1:0] ch,
                          input logic [DATA_W-1:0] d);
    eoc = 1'b1; channel = ch;
    tick;
    check({tag, "_den"},   den,   1);
    check({tag, "_dwe"},   dwe,   0);
    check({tag, "_daddr"}, daddr, {27'd0, 2'b00, ch});
    eoc = 1'b0;
    tick;
    tick;
    drdy = 1'b1; dout = d;
    tick;
    check({tag, "_valid"}, valid,    1);
    check({tag, "_data"},  data_out, d);
    drdy = 1'b0; dout = '0;
    tick;
    check({tag, "_valid_off"}, valid, 0);
  endtask

  initial begin
    rst = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; data_in = '0;
    jtaglocked = 1'b0; busy = 1'b0; drdy = 1'b0; eoc = 1'b0; eos = 1'b0;
    channel = '0; dout = '0;

    // Reset state
    repeat (3) tick;
    check("rst_den",      den,      0);
    check("rst_dwe",      dwe,      0);
    check("rst_valid",    valid,    0);
    check("rst_data_out", data_out, 0);
    check("rst_daddr",    daddr,    0);
    check("rst_din",      din,      0);
    rst = 1'b1;
    tick;

    // Single read: eoc on channel 3, drdy three cycles after den
    rd = 1'b1; eoc = 1'b1; channel = 5'h03;
    tick;
    check("rd_den",   den,   1);
    check("rd_dwe",   dwe,   0);
    check("rd_daddr", daddr, 7'h03);
    eoc = 1'b0;
    tick;
    check("rd_den_one_cycle", den,   0);
    check("rd_no_early_valid", valid, 0);
    tick;
    tick;
    drdy = 1'b1; dout = 16'hA5C3;
    tick;
    check("rd_valid", valid,    1);
    check("rd_data",  data_out, 16'hA5C3);
    drdy = 1'b0; dout = '0;
    tick;
    check("rd_valid_one_cycle", valid,    0);
    check("rd_data_hold",       data_out, 16'hA5C3);

    // Streaming: rd stays high; three conversions about 20 cycles apart
    repeat (18) tick;
    read_txn("stream0", 5'h01, 16'h1110);
    repeat (18) tick;
    read_txn("stream1", 5'h02, 16'h2220);
    repeat (18) tick;
    read_txn("stream2", 5'h04, 16'h3330);
    tick;                           // now in WAIT_EOC
    rd = 1'b0;
    tick;                           // back to IDLE
    den_snap = den_count;
    eoc = 1'b1; channel = 5'h05;
    tick;
    eoc = 1'b0;
    repeat (4) tick;
    check("stream_stop_no_den", den_count, den_snap);

    // Write with a simultaneous read request: the write wins
    wr = 1'b1; rd = 1'b1; eoc = 1'b1; channel = 5'h07;
    addr = 7'h41; data_in = 16'h2000;
    tick;
    check("wr_den",   den,   1);
    check("wr_dwe",   dwe,   1);
    check("wr_daddr", daddr, 7'h41);
    check("wr_din",   din,   16'h2000);
    wr = 1'b0; eoc = 1'b0; addr = '0; data_in = '0;
    tick;
    check("wr_den_one_cycle", den, 0);
    drdy = 1'b1;
    tick;
    check("wr_valid",            valid,    1);
    check("wr_keeps_data_out",   data_out, 16'h3330);
    drdy = 1'b0;
    tick;
    check("wr_valid_one_cycle", valid, 0);
    tick;                           // rd still high: WAIT_EOC
    read_txn("after_wr", 5'h07, 16'hBEEF);
    check("din_holds", din, 16'h2000);

    // drdy on the last wait cycle still completes the read
    tick;                           // WAIT_EOC
    eoc = 1'b1; channel = 5'h09;
    tick;
    check("tmo_edge_den", den, 1);
    eoc = 1'b0;
    repeat (TIMEOUT + 1) tick;
    drdy = 1'b1; dout = 16'h1234;
    tick;
    check("tmo_edge_valid", valid,    1);
    check("tmo_edge_data",  data_out, 16'h1234);
    drdy = 1'b0; dout = '0;
    tick;
    tick;                           // WAIT_EOC

    // drdy one cycle late: access already abandoned, eoc in RD_WAIT dropped
    eoc = 1'b1; channel = 5'h0A;
    tick;
    check("tmo_den", den, 1);
    eoc = 1'b0;
    tick;
    den_snap = den_count;
    tick;
    eoc = 1'b1; channel = 5'h0B;
    tick;
    eoc = 1'b0;
    repeat (TIMEOUT - 1) tick;
    drdy = 1'b1; dout = 16'hDEAD;
    tick;
    check("tmo_no_valid", valid, 0);
    drdy = 1'b0; dout = '0;
    tick;
    check("tmo_data_unchanged", data_out, 16'h1234);
    check("tmo_no_second_den",  den_count, den_snap);

    // The controller accepts a new read after the timeout
    eoc = 1'b1; channel = 5'h0C;
    tick;
    check("post_tmo_den",   den,   1);
    check("post_tmo_daddr", daddr, 7'h0C);
    eoc = 1'b0; rd = 1'b0;
    tick;                           // RD_WAIT

    // Asynchronous reset in the middle of RD_WAIT
    rst = 1'b0;
    #1;
    check("midrst_den",      den,      0);
    check("midrst_dwe",      dwe,      0);
    check("midrst_valid",    valid,    0);
    check("midrst_data_out", data_out, 0);
    check("midrst_daddr",    daddr,    0);
    tick;
    rst = 1'b1;
    tick;
    check("post_rst_idle", den, 0);

    // jtaglocked with a pending write
    jtaglocked = 1'b1; wr = 1'b1; addr = 7'h12; data_in = 16'h5555;
    tick;
`ifdef XADC_JTAG_LOCK_EN
    check("lock_no_den0", den, 0);
    tick;
    check("lock_no_den1", den, 0);
    jtaglocked = 1'b0;
    tick;
`endif
    check("lock_wr_den",   den,   1);
    check("lock_wr_dwe",   dwe,   1);
    check("lock_wr_daddr", daddr, 7'h12);
    check("lock_wr_din",   din,   16'h5555);
    wr = 1'b0; jtaglocked = 1'b0;
    tick;
    drdy = 1'b1;
    tick;
    check("lock_wr_valid", valid, 1);
    drdy = 1'b0;
    tick;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/xadc_drp_ctrl.md
Name: xadc_drp_ctrl

Overview:
- Controller between a user request interface and the XADC Dynamic Reconfiguration Port (DRP).
- While the user holds rd, every end-of-conversion is turned into a DRP read of the converted channel, and the 16-bit result is returned with a one-cycle valid strobe.
- A wr request performs a single DRP register write.
- Sits between the top-level sample-capture FSM and the XADC primitive wrapper.

Parameters:
- DATA_W, 16, DRP data width (data_in, data_out, din, dout).
- ADDR_W, 7, DRP address width (addr, daddr).
- CH_W, 5, XADC channel field width.
- TIMEOUT, 255, maximum cycles to wait for drdy before aborting an access.

Ports:
- clk  in  1  DRP/system clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- rd  in  1  level; while high, read each completed conversion.
- wr  in  1  single-cycle request: write data_in to DRP address addr.
- addr  in  ADDR_W  DRP write address.
- data_in  in  DATA_W  DRP write data.
- data_out  out  DATA_W  last DRP read result.
- valid  out  1  one-cycle strobe on completion of a read or a write.
- jtaglocked  in  1  XADC JTAG lock status.
- busy  in  1  XADC busy; status only, does not gate DRP.
- drdy  in  1  DRP ready/acknowledge.
- eoc  in  1  end-of-conversion pulse.
- eos  in  1  end-of-sequence pulse; unused, no effect on behaviour.
- channel  in  CH_W  channel of the current conversion.
- dout  in  DATA_W  DRP read data.
- dwe  out  1  DRP write enable.
- den  out  1  DRP enable, one-cycle pulse per access.
- daddr  out  ADDR_W  DRP address.
- din  out  DATA_W  DRP write data.

Behaviour:
- Reset (rst low, async): state IDLE. data_out, din, daddr and counter are 0; valid, den, dwe are 0. Any in-flight access is abandoned.
- States: IDLE, WAIT_EOC, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, DONE.
- IDLE:
  - wr high: latch addr and data_in, go to WR_REQ. wr has priority over rd.
  - else rd && eoc: latch daddr = {zero-pad, channel}, go to RD_REQ.
  - else rd: go to WAIT_EOC.
- WAIT_EOC:
  - eoc: latch channel into daddr, go to RD_REQ.
  - rd low (and no eoc): return to IDLE.
  - wr is ignored here.
- RD_REQ: den=1, dwe=0 for exactly one cycle; clear counter; go to RD_WAIT.
- RD_WAIT:
  - drdy: register data_out <= dout, go to DONE.
  - counter reaches TIMEOUT: go to IDLE; data_out unchanged; no valid.
- WR_REQ: den=1, dwe=1, din = latched data, one cycle; go to WR_WAIT.
- WR_WAIT: on drdy go to DONE; same TIMEOUT rule as RD_WAIT.
- DONE: valid=1 for one cycle; go to IDLE. If rd is still high, the next eoc starts a new read.
- Latency:
  - eoc sampled in cycle T → den in T+1.
  - drdy sampled in cycle D → data_out updated at D+1, valid high in D+1 (DONE).
  - wr sampled in T → den/dwe in T+1.
- Ignored events:
  - eoc arriving while in RD_REQ, RD_WAIT, WR_*, DONE is dropped; no queuing.
  - drdy outside a WAIT state is ignored.
- data_out holds its value between reads; writes do not modify it.
- daddr and din hold their last values when den=0.

Optional Feature:
- Macro: XADC_JTAG_LOCK_EN.
- Defined: while jtaglocked=1, IDLE and WAIT_EOC do not leave toward RD_REQ/WR_REQ. Requests stay pending and are accepted on the first cycle jtaglocked=0 (wr must still be high, rd still high, eoc for reads). Accesses already issued complete normally.
- Not defined: jtaglocked is ignored.

Test Plan:
- Reset: drive rst=0 mid-RD_WAIT → den=0, dwe=0, valid=0, data_out=0 immediately; after release, controller is in IDLE.
- Read: rd=1, eoc pulse with channel=5'h03; drdy 3 cycles after den with dout=16'hA5C3 → den one cycle with daddr=7'h03 and dwe=0; data_out=16'hA5C3 and valid=1 for exactly one cycle.
- Streaming: rd held high, three eoc pulses 20 cycles apart with dout 16'h1110, 16'h2220, 16'h3330 → three valid strobes, data_out sequence matches; rd low in WAIT_EOC → back to IDLE, no further den.
- Write and priority: wr=1 and rd=1 same cycle with addr=7'h41, data_in=16'h2000 → den=1, dwe=1, daddr=7'h41, din=16'h2000; valid after drdy; read starts only afterwards.
- Timeout: read issued, drdy never asserted → returns to IDLE after TIMEOUT cycles; no valid; data_out unchanged; eoc during RD_WAIT produces no second den.
- JTAG lock (XADC_JTAG_LOCK_EN defined): jtaglocked=1 with wr=1 → no den; drop jtaglocked to 0 with wr still 1 → den/dwe next cycle.
